// File: rtl/alu_seq_pkg.sv
// Shared constants for the ALU sequencer: FSM state encoding, default widths,
// and the width of the EXEC wait counter.
package alu_seq_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int OP_W_DEF   = 3;

    // EXEC_WAIT ranges 0..15, so a 4-bit counter covers it
    localparam int EXEC_CNT_W = 4;

    // Completed-operation counter width
    localparam int OPCNT_W    = 16;

    // FSM state encoding (3-bit, kept as plain constants for legacy tools)
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD_A = 3'd1;
    localparam logic [2:0] ST_LOAD_B = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_DRIVE  = 3'd4;
    localparam logic [2:0] ST_RESP   = 3'd5;

endpackage

// File: rtl/alu_seq_opcnt.sv
// 16-bit saturating counter of completed ALU operations.
// Increments once per inc pulse, sticks at all-ones, cleared only by reset.
module alu_seq_opcnt
    import alu_seq_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               inc,
    output logic [OPCNT_W-1:0] count
);

    logic [OPCNT_W-1:0] count_reg;

    // Count completions; hold once the counter reaches its maximum
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
        end else if (inc && (count_reg != '1)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/alu_seq_ctrl.sv
// ALU datapath sequencer. Takes one {op, a, b} instruction per handshake and walks
// the datapath through LOAD_A, LOAD_B, EXEC, DRIVE, then offers the captured result.
// All outputs are registered: the next-state decode is computed combinationally and
// the strobes are loaded into flops together with the state.
// Optional feature: define ALU_SEQ_OPCOUNT_EN to enable the completed-op counter;
// otherwise op_count is tied to zero.
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int OP_W      = OP_W_DEF,
    parameter int EXEC_WAIT = 0
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [OP_W-1:0]    instr_op,
    input  logic [DATA_W-1:0]  instr_a,
    input  logic [DATA_W-1:0]  instr_b,
    output logic               result_valid,
    input  logic               result_ready,
    output logic [DATA_W-1:0]  result_data,
    output logic [DATA_W-1:0]  bus_drv,
    input  logic [DATA_W-1:0]  dp_bus,
    output logic [OP_W-1:0]    opCode,
    output logic               ALUin1,
    output logic               ALUin2,
    output logic               ALU_outlach,
    output logic               ALU_outEN,
    output logic [OPCNT_W-1:0] op_count
);

    localparam logic [EXEC_CNT_W-1:0] EXEC_WAIT_C = EXEC_CNT_W'(EXEC_WAIT);

    logic [2:0]            state_reg,        state_next;
    logic [OP_W-1:0]       op_reg,           op_next;
    logic [DATA_W-1:0]     a_reg,            a_next;
    logic [DATA_W-1:0]     b_reg,            b_next;
    logic [DATA_W-1:0]     result_reg,       result_next;
    logic [EXEC_CNT_W-1:0] wait_cnt_reg,     wait_cnt_next;

    logic                  instr_ready_reg,  instr_ready_next;
    logic                  alu_in1_reg,      alu_in1_next;
    logic                  alu_in2_reg,      alu_in2_next;
    logic                  alu_outlach_reg,  alu_outlach_next;
    logic                  alu_out_en_reg,   alu_out_en_next;
    logic                  result_valid_reg, result_valid_next;
    logic [DATA_W-1:0]     bus_drv_reg,      bus_drv_next;
    logic [OP_W-1:0]       op_code_reg,      op_code_next;

    logic                  accept;

    // instr_ready is itself registered, so right after reset release the FSM sits in
    // IDLE for one cycle without accepting anything.
    assign accept = instr_valid && instr_ready_reg;

    // Next-state logic and operand/result holding registers
    always_comb begin
        state_next    = state_reg;
        op_next       = op_reg;
        a_next        = a_reg;
        b_next        = b_reg;
        result_next   = result_reg;
        wait_cnt_next = wait_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    state_next = ST_LOAD_A;
                    op_next    = instr_op;
                    a_next     = instr_a;
                    b_next     = instr_b;
                end
            end
            ST_LOAD_A: state_next = ST_LOAD_B;
            ST_LOAD_B: begin
                state_next    = ST_EXEC;
                wait_cnt_next = '0;
            end
            ST_EXEC: begin
                // The cycle that carries the latch strobe is the last one in EXEC
                if (alu_outlach_reg) begin
                    state_next = ST_DRIVE;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                end
            end
            ST_DRIVE: begin
                state_next  = ST_RESP;
                result_next = dp_bus;
            end
            ST_RESP: begin
                if (result_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state so every output comes straight from a flop
    always_comb begin
        instr_ready_next  = (state_next == ST_IDLE);
        alu_in1_next      = (state_next == ST_LOAD_A);
        alu_in2_next      = (state_next == ST_LOAD_B);
        alu_outlach_next  = (state_next == ST_EXEC) && (wait_cnt_next == EXEC_WAIT_C);
        alu_out_en_next   = (state_next == ST_DRIVE);
        result_valid_next = (state_next == ST_RESP);
        bus_drv_next      = '0;
        if (state_next == ST_LOAD_A) begin
            bus_drv_next = a_next;
        end else if (state_next == ST_LOAD_B) begin
            bus_drv_next = b_next;
        end
        op_code_next = '0;
        if (state_next inside {ST_LOAD_A, ST_LOAD_B, ST_EXEC, ST_DRIVE}) begin
            op_code_next = op_next;
        end
    end

    // State, held operands and registered outputs; reset aborts any operation
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg        <= ST_IDLE;
            op_reg           <= '0;
            a_reg            <= '0;
            b_reg            <= '0;
            result_reg       <= '0;
            wait_cnt_reg     <= '0;
            instr_ready_reg  <= 1'b0;
            alu_in1_reg      <= 1'b0;
            alu_in2_reg      <= 1'b0;
            alu_outlach_reg  <= 1'b0;
            alu_out_en_reg   <= 1'b0;
            result_valid_reg <= 1'b0;
            bus_drv_reg      <= '0;
            op_code_reg      <= '0;
        end else begin
            state_reg        <= state_next;
            op_reg           <= op_next;
            a_reg            <= a_next;
            b_reg            <= b_next;
            result_reg       <= result_next;
            wait_cnt_reg     <= wait_cnt_next;
            instr_ready_reg  <= instr_ready_next;
            alu_in1_reg      <= alu_in1_next;
            alu_in2_reg      <= alu_in2_next;
            alu_outlach_reg  <= alu_outlach_next;
            alu_out_en_reg   <= alu_out_en_next;
            result_valid_reg <= result_valid_next;
            bus_drv_reg      <= bus_drv_next;
            op_code_reg      <= op_code_next;
        end
    end

    assign instr_ready  = instr_ready_reg;
    assign ALUin1       = alu_in1_reg;
    assign ALUin2       = alu_in2_reg;
    assign ALU_outlach  = alu_outlach_reg;
    assign ALU_outEN    = alu_out_en_reg;
    assign result_valid = result_valid_reg;
    assign result_data  = result_reg;
    assign bus_drv      = bus_drv_reg;
    assign opCode       = op_code_reg;

`ifdef ALU_SEQ_OPCOUNT_EN
    logic op_done;

    // One completion per RESP handshake
    assign op_done = (state_reg == ST_RESP) && result_ready;

    alu_seq_opcnt u_opcnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (op_done),
        .count (op_count)
    );
`else
    assign op_count = '0;
`endif

endmodule
